// File: rtl/morse_tx_encoder.sv
// morse_tx_encoder: keys handshaked ASCII characters out as International Morse on a registered line
module morse_tx_encoder #(
   parameter int WORD_BITS   = 8,
   parameter int UNIT_CYCLES = 12000000,
   parameter int UNIT_BITS   = $clog2(UNIT_CYCLES)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [WORD_BITS-1:0] char_i,
   input  logic                 char_valid_i,
   output logic                 char_ready_o,
   output logic                 morse_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);
   typedef enum logic [2:0] {IDLE, LOAD, MARK, ELEM_GAP, LETTER_GAP, WORD_GAP} state_t;
   function automatic logic [7:0] rom(input logic [WORD_BITS-1:0] c);
      logic [WORD_BITS-1:0] u;
      logic [7:0] code;
      u = (c >= WORD_BITS'(97) && c <= WORD_BITS'(122)) ? c - WORD_BITS'(32) : c;
      case (u[7:0])
         8'h41: code = {3'd2, 5'b00001};
         8'h42: code = {3'd4, 5'b01000};
         8'h43: code = {3'd4, 5'b01010};
         8'h44: code = {3'd3, 5'b00100};
         8'h45: code = {3'd1, 5'b00000};
         8'h46: code = {3'd4, 5'b00010};
         8'h47: code = {3'd3, 5'b00110};
         8'h48: code = {3'd4, 5'b00000};
         8'h49: code = {3'd2, 5'b00000};
         8'h4a: code = {3'd4, 5'b00111};
         8'h4b: code = {3'd3, 5'b00101};
         8'h4c: code = {3'd4, 5'b00100};
         8'h4d: code = {3'd2, 5'b00011};
         8'h4e: code = {3'd2, 5'b00010};
         8'h4f: code = {3'd3, 5'b00111};
         8'h50: code = {3'd4, 5'b00110};
         8'h51: code = {3'd4, 5'b01101};
         8'h52: code = {3'd3, 5'b00010};
         8'h53: code = {3'd3, 5'b00000};
         8'h54: code = {3'd1, 5'b00001};
         8'h55: code = {3'd3, 5'b00001};
         8'h56: code = {3'd4, 5'b00001};
         8'h57: code = {3'd3, 5'b00011};
         8'h58: code = {3'd4, 5'b01001};
         8'h59: code = {3'd4, 5'b01011};
         8'h5a: code = {3'd4, 5'b01100};
         8'h30: code = {3'd5, 5'b11111};
         8'h31: code = {3'd5, 5'b01111};
         8'h32: code = {3'd5, 5'b00111};
         8'h33: code = {3'd5, 5'b00011};
         8'h34: code = {3'd5, 5'b00001};
         8'h35: code = {3'd5, 5'b00000};
         8'h36: code = {3'd5, 5'b10000};
         8'h37: code = {3'd5, 5'b11000};
         8'h38: code = {3'd5, 5'b11100};
         8'h39: code = {3'd5, 5'b11110};
         default: code = 8'h00;
      endcase
      return (u >> 8) == '0 ? code : 8'h00;
   endfunction
   state_t state, next_state;
   logic [WORD_BITS-1:0] char_q;
   logic [UNIT_BITS-1:0] ucnt;
   logic [1:0] units, unit_load;
   logic [4:0] sh, rom_pat, rom_sh;
   logic [2:0] rem, rom_len;
   logic hs, wrap, last, entry, is_space, dash_next;
   assign hs        = char_valid_i & char_ready_o;
   assign {rom_len, rom_pat} = rom(char_q);
   assign rom_sh    = rom_pat << (3'd5 - rom_len);
   assign is_space  = char_q == WORD_BITS'(32);
   assign wrap      = ucnt == UNIT_BITS'(UNIT_CYCLES - 1);
   assign last      = wrap && units == 2'd0;
   assign entry     = next_state != state;
   assign dash_next = state == LOAD ? rom_sh[4] : sh[3];
   assign unit_load = next_state == MARK ? (dash_next ? 2'd2 : 2'd0) :
                      next_state == LETTER_GAP ? 2'd2 :
                      next_state == WORD_GAP ? 2'd3 : 2'd0;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:                 next_state = hs ? LOAD : IDLE;
         LOAD:                 next_state = rom_len != 3'd0 ? MARK : is_space ? WORD_GAP : IDLE;
         MARK:                 next_state = last ? (rem != 3'd0 ? ELEM_GAP : LETTER_GAP) : MARK;
         ELEM_GAP:             next_state = last ? MARK : ELEM_GAP;
         LETTER_GAP, WORD_GAP: next_state = last ? IDLE : state;
         default:              next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state        <= IDLE;
         char_q       <= '0;
         ucnt         <= '0;
         units        <= 2'd0;
         sh           <= 5'd0;
         rem          <= 3'd0;
         char_ready_o <= 1'b1;
         morse_o      <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         state        <= next_state;
         ucnt         <= (entry || wrap) ? '0 : ucnt + 1'b1;
         units        <= entry ? unit_load : wrap ? units - 2'd1 : units;
         if (hs) char_q <= char_i;
         if (state == LOAD) begin
            sh  <= rom_sh;
            rem <= rom_len - 3'd1;
         end else if (state == ELEM_GAP && last) begin
            sh  <= sh << 1;
            rem <= rem - 3'd1;
         end
         char_ready_o <= state == IDLE && !hs;
         morse_o      <= state == MARK;
         busy_o       <= state != IDLE;
         done_o       <= (state == LETTER_GAP || state == WORD_GAP) && last;
         err_o        <= hs && rom(char_i) == 8'h00 && char_i != WORD_BITS'(32);
      end
   end
endmodule

// File: tb/tb_morse_tx_encoder.sv
// tb_morse_tx_encoder: checks keyed waveforms against a dot/dash string model of International Morse
module tb_morse_tx_encoder;
   localparam int U = 4;
   logic clk, reset_i, char_valid_i, char_ready_o, morse_o, busy_o, done_o, err_o;
   logic [7:0] char_i;
   int vectors = 0, miss = 0;
   logic [4:0] exp_q[$], obs_q[$];
   string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--.."};
   string digits[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
   morse_tx_encoder #(.WORD_BITS(8), .UNIT_CYCLES(U)) dut (
      .clk_i(clk), .reset_i(reset_i), .char_i(char_i), .char_valid_i(char_valid_i),
      .char_ready_o(char_ready_o), .morse_o(morse_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic build_expect(input logic [7:0] c);
      string code;
      int kind, t;
      bit wave[$];
      logic [7:0] uc;
      code = "";
      kind = 0;
      uc = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
      if (uc >= 8'h41 && uc <= 8'h5a) begin
         code = letters[int'(uc) - 65];
         kind = 1;
      end else if (uc >= 8'h30 && uc <= 8'h39) begin
         code = digits[int'(uc) - 48];
         kind = 1;
      end else if (c == 8'h20) kind = 2;
      for (int i = 0; i < code.len(); i++) begin
         repeat ((code[i] == 8'h2d ? 3 : 1) * U) wave.push_back(1'b1);
         repeat ((i == code.len() - 1 ? 3 : 1) * U) wave.push_back(1'b0);
      end
      if (kind == 2) repeat (4 * U) wave.push_back(1'b0);
      t = wave.size();
      exp_q.delete();
      for (int s = 0; s <= t + 2; s++)
         exp_q.push_back({(s >= 2 && s <= t + 1) ? wave[s-2] : 1'b0, s >= 1 && s <= t + 1,
                          s == t + 2, kind != 0 && s == t + 1, kind == 0 && s == 0});
   endtask
   task automatic drive_char(input logic [7:0] c, input bit noise);
      int n;
      n = 0;
      build_expect(c);
      while (char_ready_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         vectors++;
         miss++;
         $display("FAIL ready_timeout char=%h ready=%b want 1", c, char_ready_o);
      end
      char_i = c;
      char_valid_i = 1'b1;
      @(posedge clk);
      #1 char_valid_i = 1'b0;
      char_i = 8'($urandom);
      obs_q.delete();
      for (int s = 0; s < exp_q.size(); s++) begin
         @(negedge clk);
         obs_q.push_back({morse_o, busy_o, char_ready_o, done_o, err_o});
         char_valid_i = noise && s <= exp_q.size() - 3 ? 1'($urandom) : 1'b0;
         char_i = 8'($urandom);
      end
      char_valid_i = 1'b0;
   endtask
   task automatic test_reset;
      reset_i = 1'b0;
      char_valid_i = 1'b1;
      char_i = 8'h45;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({morse_o, busy_o, char_ready_o, done_o, err_o} !== 5'b00100) begin
         miss++;
         $display("FAIL reset_state got %b want 00100", {morse_o, busy_o, char_ready_o, done_o, err_o});
      end
      char_valid_i = 1'b0;
      reset_i = 1'b1;
   endtask
   task automatic test_letter_e;
      drive_char(8'h45, 1'b0);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miss++;
            $display("FAIL letter_E s=%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask
   task automatic test_back_to_back;
      logic [7:0] seq[2] = '{8'h41, 8'h61};
      foreach (seq[k]) begin
         drive_char(seq[k], 1'b0);
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miss++;
               $display("FAIL back_to_back char=%h s=%0d got %b want %b", seq[k], i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask
   task automatic test_digit_zero;
      drive_char(8'h30, 1'b1);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miss++;
            $display("FAIL digit_0 s=%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask
   task automatic test_space;
      drive_char(8'h20, 1'b1);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miss++;
            $display("FAIL space s=%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask
   task automatic test_unsupported;
      logic [7:0] bad[3] = '{8'h23, 8'h7f, 8'h2e};
      foreach (bad[k]) begin
         drive_char(bad[k], 1'b1);
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miss++;
               $display("FAIL unsupported char=%h s=%0d got %b want %b", bad[k], i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask
   task automatic test_reset_mid_char;
      char_i = 8'h54;
      char_valid_i = 1'b1;
      @(posedge clk);
      #1 char_valid_i = 1'b0;
      repeat (7) @(negedge clk);
      vectors++;
      if (morse_o !== 1'b1) begin
         miss++;
         $display("FAIL mid_dash morse=%b want 1", morse_o);
      end
      reset_i = 1'b0;
      @(negedge clk);
      vectors++;
      if ({morse_o, busy_o, char_ready_o, done_o, err_o} !== 5'b00100) begin
         miss++;
         $display("FAIL reset_abort got %b want 00100", {morse_o, busy_o, char_ready_o, done_o, err_o});
      end
      reset_i = 1'b1;
      drive_char(8'h45, 1'b0);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miss++;
            $display("FAIL after_reset_E s=%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask
   task automatic test_random;
      logic [7:0] c;
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 4))
            0: c = 8'($urandom);
            1: c = 8'h41 + 8'($urandom_range(0, 25));
            2: c = 8'h61 + 8'($urandom_range(0, 25));
            3: c = 8'h30 + 8'($urandom_range(0, 9));
            default: c = 8'h20;
         endcase
         drive_char(c, 1'($urandom));
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miss++;
               $display("FAIL random char=%h s=%0d got %b want %b", c, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask
   initial begin
      reset_i = 1'b0;
      char_valid_i = 1'b0;
      char_i = 8'h00;
      test_reset;
      test_letter_e;
      test_back_to_back;
      test_digit_zero;
      test_space;
      test_unsupported;
      test_reset_mid_char;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end
endmodule
